// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// Multiplies two 32-bit operands by shift-and-add, borrowing a shared ALU
// for every add and every shift. The product is the low 32 bits, so the
// result is the same whether the operands are read as signed or unsigned.
//
// Each iteration takes two ALU slots:
//   ADD : acc   <= acc + (mplr[0] ? mcand : 0)
//   SHL : mcand <= mcand << 1, mplr <= mplr >> 1
// The loop ends once no set bits of the multiplier remain, or after 32
// iterations.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ALU outputs parked
// ADD   | requesting ALU add of the partial product into acc
// SHL   | requesting ALU shift of mcand; shift mplr, count iteration
// DONE  | one-cycle done pulse; result loaded from acc
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, flush          begin an operation / abort it synchronously
//   op_a, op_b            multiplicand / multiplier, sampled with start
//   busy, done, result    status, completion pulse, product (low 32 bits)
//   alu_req, alu_gnt      shared ALU request / grant
//   alu_op1/op2/ctrl      ALU operands and operation
//   alu_out               combinational ALU result
// ---------------------------------------------------------------------------
module mul_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out
);

    // ALU operation encodings shared with the datapath ALU
    localparam logic [3:0] ALU_SLL = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_SHL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [31:0] acc_q,    acc_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplr_q,   mplr_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] result_q, result_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        alu_req  = 1'b0;
        alu_op1  = 32'd0;
        alu_op2  = 32'd0;
        alu_ctrl = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = 32'd0;
                    if (op_b != 32'd0) begin
                        mcand_d = op_a;
                        mplr_d  = op_b;
                        cnt_d   = 5'd0;
                        state_d = S_ADD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADD: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_op1  = acc_q;
                alu_op2  = mplr_q[0] ? mcand_q : 32'd0;
                if (alu_gnt) begin
                    acc_d   = alu_out;
                    state_d = S_SHL;
                end
            end
            S_SHL: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_SLL;
                alu_op1  = mcand_q;
                alu_op2  = 32'd1;
                if (alu_gnt) begin
                    mcand_d = alu_out;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q + 5'd1;
                    // Decided on the pre-shift multiplier: nothing left above bit 0
                    if (cnt_q == 5'd31 || mplr_q[31:1] == 31'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            default: begin
                result_d = acc_q;
                state_d  = S_IDLE;
            end
        endcase

        // Abort wins over start and grant; work in flight is dropped untouched
        if (flush) begin
            state_d  = S_IDLE;
            acc_d    = acc_q;
            mcand_d  = mcand_q;
            mplr_d   = mplr_q;
            cnt_d    = cnt_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplr_q   <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    localparam logic [3:0] C_SLL = 4'd0;
    localparam logic [3:0] C_ADD = 4'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb_res[$];
    int          sb_lat[$];
    int          sb_req[$];

    always #5 clk = ~clk;

    // Reference ALU
    assign alu_out = (alu_ctrl == C_ADD) ? alu_op1 + alu_op2 :
                     (alu_ctrl == C_SLL) ? alu_op1 << alu_op2[4:0] : 32'hDEAD_BEEF;

    mul_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int calc_k(input logic [31:0] b);
        for (int i = 31; i >= 0; i--)
            if (b[i]) return i + 1;
        return 0;
    endfunction

    // Runs one operation; expectations are queued at start and checked when done appears.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len, input int extra_at);
        int          cyc;
        int          req_cnt;
        bit          seen;
        logic [31:0] frozen;
        int          k;
        k = calc_k(b);
        sb_res.push_back(a * b);
        sb_lat.push_back(1 + 2 * k + ((stall_at >= 0) ? stall_len : 0));
        sb_req.push_back(2 * k + ((stall_at >= 0) ? stall_len : 0));

        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        cyc = 0; req_cnt = 0; seen = 0; frozen = 32'd0;
        @(negedge clk);
        while (!seen && cyc < 200) begin
            if (cyc == extra_at) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (stall_at >= 0 && cyc == stall_at) frozen = alu_op1;
            if (stall_at >= 0 && cyc > stall_at && cyc <= stall_at + stall_len)
                chk("stall_frozen_op1", alu_op1, frozen);
            alu_gnt = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : 1'b1;
            if (alu_req) req_cnt++;
            if (done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", cyc + 1, sb_lat.pop_front());
        chk("alu_req_cycles", req_cnt, sb_req.pop_front());
        @(posedge clk);
        #1;
        chk("result", result, sb_res.pop_front());
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_op1", alu_op1, 32'd0);
        chk("idle_ctrl", {28'd0, alu_ctrl}, {28'd0, C_ADD});
    endtask

    task automatic flush_op(input logic [31:0] a, input logic [31:0] b, input int flush_at);
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < flush_at; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("flush_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("flush_result_kept", result, prev);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy",   {31'd0, busy},    32'd0);
        chk("rst_done",   {31'd0, done},    32'd0);
        chk("rst_result", result,           32'd0);
        chk("rst_req",    {31'd0, alu_req}, 32'd0);
        chk("rst_op1",    alu_op1,          32'd0);
        chk("rst_op2",    alu_op2,          32'd0);
        chk("rst_ctrl",   {28'd0, alu_ctrl}, {28'd0, C_ADD});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5, -1, 0, -1);
        run_op(32'd9, 32'd0, -1, 0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, -1);
        run_op(32'd7, 32'd6, 2, 4, -1);
        run_op(32'd3, 32'd5, -1, 0, 2);
        run_op(32'hFFFF_FFFD, 32'd7, -1, 0, -1);
        run_op(32'd1, 32'h8000_0000, -1, 0, -1);
        for (int i = 0; i < 4; i++)
            run_op($urandom, $urandom_range(1, 255), -1, 0, -1);
        run_op($urandom, $urandom, 3, 2, -1);

        // Flush while in SHL (one edge after entering ADD)
        flush_op(32'd11, 32'd13, 1);

        // Asynchronous reset mid-operation
        @(negedge clk);
        op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy},    32'd0);
        chk("arst_done",   {31'd0, done},    32'd0);
        chk("arst_result", result,           32'd0);
        chk("arst_req",    {31'd0, alu_req}, 32'd0);
        chk("arst_op1",    alu_op1,          32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 32'd2, -1, 0, -1);

        chk("scoreboard_empty", sb_res.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port flush  input  1  synchronous abort of the current operation.
REQ-005 SHALL have port op_a  input  32  multiplicand; sampled with start.
REQ-006 SHALL have port op_b  input  32  multiplier; sampled with start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result  output  32  low 32 bits of op_a*op_b.
REQ-010 SHALL have port alu_req  output  1  request for the shared ALU.
REQ-011 SHALL have port alu_gnt  input  1  ALU granted this cycle.
REQ-012 SHALL have port alu_op1  output  32  ALU Operand1.
REQ-013 SHALL have port alu_op2  output  32  ALU Operand2.
REQ-014 SHALL have port alu_ctrl  output  4  ALU control; uses the Parameters.v ADD and SLL encodings.
REQ-015 SHALL have port alu_out  input  32  combinational ALU result for the current alu_op1/alu_op2/alu_ctrl.

Function
REQ-016 SHALL implement the FSM states IDLE, ADD, SHL and DONE, plus internal registers acc[31:0], mcand[31:0], mplr[31:0] and cnt[4:0].
REQ-017 SHALL, in IDLE with start=1 and op_b!=0, load mcand=op_a, mplr=op_b, acc=0, cnt=0, and go to ADD.
REQ-018 SHALL, in IDLE with start=1 and op_b==0, load acc=0 and go directly to DONE.
REQ-019 SHALL drive, in ADD: alu_req=1, alu_ctrl=ADD, alu_op1=acc, alu_op2=(mplr[0] ? mcand : 0).
REQ-020 SHALL, in ADD with alu_gnt=1, capture acc<=alu_out and go to SHL; with alu_gnt=0, hold state and registers.
REQ-021 SHALL drive, in SHL: alu_req=1, alu_ctrl=SLL, alu_op1=mcand, alu_op2=32'd1.
REQ-022 SHALL, in SHL with alu_gnt=1, capture mcand<=alu_out, mplr<=mplr>>1, cnt<=cnt+1; go to DONE if cnt==31 or mplr[31:1]==0, else to ADD; with alu_gnt=0, hold.
REQ-023 SHALL assert done=1 for exactly the one DONE cycle, load result<=acc on that cycle's edge, then go to IDLE.
REQ-024 SHALL hold result stable from DONE until the next DONE.
REQ-025 SHALL drive alu_req=0, alu_op1=0, alu_op2=0 and alu_ctrl=ADD in IDLE and DONE.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL, on flush=1 in any state, go to IDLE next cycle with no done pulse and result unchanged; flush has priority over start and alu_gnt.
REQ-028 SHALL complete with latency 1+2k cycles from the start edge, where k = (bit index of the highest set bit of op_b) + 1 and alu_gnt is held at 1; each alu_gnt=0 cycle in ADD/SHL adds one cycle.
REQ-029 SHALL wrap all arithmetic modulo 2^32 (ALU result width), so the result is identical for signed and unsigned operands.
REQ-030 SHALL update acc/mcand only from alu_out, never from a local adder or shifter.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, done=0, result=0, alu_req=0, and acc/mcand/mplr/cnt=0.
REQ-032 SHALL discard an operation interrupted by reset; after rst_n rises, the first start begins a fresh operation.

Verification
REQ-033 SHALL cover: start, op_a=3, op_b=5, gnt=1 -> done at start+7, result=15.
REQ-034 SHALL cover: start, op_b=0 -> done at start+1, result=0, alu_req never asserted.
REQ-035 SHALL cover: op_a=op_b=32'hFFFFFFFF, gnt=1 -> 32 iterations, done at start+65, result=32'h00000001.
REQ-036 SHALL cover: op_a=7, op_b=6, alu_gnt=0 for 4 cycles mid-operation -> done at start+11, result=42, registers frozen while not granted.
REQ-037 SHALL cover: start asserted while busy -> ignored, first result unaffected; flush in SHL -> IDLE next cycle, no done, prior result retained.
REQ-038 SHALL cover: rst_n pulsed low mid-operation -> all outputs zero asynchronously; a new start after release (op_a=2, op_b=2) -> result=4.
